// File: rtl/ttc_count_sched24.sv
// Per-channel clock-control registers and prescalers producing count-enable pulses for three timer counters.
// Optional external count-clock path is built only when TTC_EXT_CLK_EN is defined.
module ttc_count_sched24 (
    input  logic        pclk24,
    input  logic        p_reset24,
    input  logic [15:0] pwdata24,
    input  logic [2:0]  clk_ctrl_reg_sel24,
    input  logic        sync_restart24,
    input  logic [2:0]  ext_clk24,
    output logic [20:0] clk_ctrl_reg_out24,
    output logic [2:0]  count_en24
);

    logic [2:0][6:0]  ctrl_r;
    logic [2:0][15:0] pre_cnt_r;
    logic [2:0]       en_r;
    logic [2:0][15:0] limit_s;
    logic [2:0]       tick_s;
    logic [6:0]       wr_data_s;
    logic             unused_s;

    // Terminal count for divide-by-2^(N+1); N=15 yields 16'hFFFF.
    function automatic logic [15:0] wrap_limit(input logic [3:0] n);
        logic [16:0] full;
        full = (17'd1 << ({1'b0, n} + 5'd1)) - 17'd1;
        return full[15:0];
    endfunction

`ifdef TTC_EXT_CLK_EN
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] hist_r;

    assign wr_data_s = pwdata24[6:0];
    assign unused_s  = ^pwdata24[15:7];

    // Synchronize external clocks; history flop tracks regardless of selected source.
    always_ff @(posedge pclk24 or posedge p_reset24) begin
        if (p_reset24) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            hist_r  <= 3'b000;
        end else begin
            sync1_r <= ext_clk24;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Select tick source and edge direction per channel.
    always_comb begin
        tick_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (ctrl_r[i][5]) begin
                if (ctrl_r[i][6]) begin
                    tick_s[i] = hist_r[i] & ~sync2_r[i];
                end else begin
                    tick_s[i] = sync2_r[i] & ~hist_r[i];
                end
            end else begin
                tick_s[i] = 1'b1;
            end
        end
    end
`else
    // Without the external path, source and edge bits are forced to zero.
    assign wr_data_s = {2'b00, pwdata24[4:0]};
    assign unused_s  = ^{ext_clk24, pwdata24[15:5]};

    // Every pclk24 cycle is a tick.
    always_comb begin
        tick_s = 3'b111;
    end
`endif

    // Per-channel terminal count from the stored prescale value.
    always_comb begin
        limit_s = '0;
        for (int i = 0; i < 3; i++) begin
            limit_s[i] = wrap_limit(ctrl_r[i][4:1]);
        end
    end

    // Register loads, prescale counting and count-enable generation.
    always_ff @(posedge pclk24 or posedge p_reset24) begin
        if (p_reset24) begin
            ctrl_r    <= '0;
            pre_cnt_r <= '0;
            en_r      <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clk_ctrl_reg_sel24[i]) begin
                    ctrl_r[i] <= wr_data_s;
                end
                // A write or restart discards any tick seen this cycle.
                if (clk_ctrl_reg_sel24[i] || sync_restart24) begin
                    pre_cnt_r[i] <= 16'd0;
                    en_r[i]      <= 1'b0;
                end else if (tick_s[i]) begin
                    if (!ctrl_r[i][0]) begin
                        pre_cnt_r[i] <= 16'd0;
                        en_r[i]      <= 1'b1;
                    end else if (pre_cnt_r[i] == limit_s[i]) begin
                        pre_cnt_r[i] <= 16'd0;
                        en_r[i]      <= 1'b1;
                    end else begin
                        pre_cnt_r[i] <= pre_cnt_r[i] + 16'd1;
                        en_r[i]      <= 1'b0;
                    end
                end else begin
                    en_r[i] <= 1'b0;
                end
            end
        end
    end

    assign clk_ctrl_reg_out24 = {ctrl_r[2], ctrl_r[1], ctrl_r[0]};
    assign count_en24         = en_r;

endmodule

// File: tb/tb_ttc_count_sched24.sv
// Directed bench for ttc_count_sched24: expectations queued before each edge, checked 1 time unit after it.
module tb_ttc_count_sched24;

    logic        pclk24 = 1'b0;
    logic        p_reset24;
    logic [15:0] pwdata24;
    logic [2:0]  clk_ctrl_reg_sel24;
    logic        sync_restart24;
    logic [2:0]  ext_clk24;
    logic [20:0] clk_ctrl_reg_out24;
    logic [2:0]  count_en24;

    typedef struct {
        string       tag;
        logic [2:0]  en;
        logic [20:0] regs;
    } exp_t;

    exp_t        sb_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [20:0] exp_regs;

    ttc_count_sched24 dut (
        .pclk24             (pclk24),
        .p_reset24          (p_reset24),
        .pwdata24           (pwdata24),
        .clk_ctrl_reg_sel24 (clk_ctrl_reg_sel24),
        .sync_restart24     (sync_restart24),
        .ext_clk24          (ext_clk24),
        .clk_ctrl_reg_out24 (clk_ctrl_reg_out24),
        .count_en24         (count_en24)
    );

    always #5 pclk24 = ~pclk24;

    task automatic expect_now(input string tag, input logic [2:0] en);
        exp_t e;
        e.tag  = tag;
        e.en   = en;
        e.regs = exp_regs;
        sb_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb_q.pop_front();
        compared++;
        assert (count_en24 === e.en) else begin
            mismatched++;
            $error("FAIL %s count_en24 got %b want %b", e.tag, count_en24, e.en);
        end
        compared++;
        assert (clk_ctrl_reg_out24 === e.regs) else begin
            mismatched++;
            $error("FAIL %s clk_ctrl_reg_out24 got %h want %h", e.tag, clk_ctrl_reg_out24, e.regs);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] en);
        expect_now(tag, en);
        @(posedge pclk24);
        #1;
        compare_front();
    endtask

    task automatic wr(input logic [2:0] sel, input logic [15:0] data, input logic [6:0] stored,
                      input logic [2:0] en_after, input string tag);
        clk_ctrl_reg_sel24 = sel;
        pwdata24           = data;
        for (int c = 0; c < 3; c++) begin
            if (sel[c]) exp_regs[7*c +: 7] = stored;
        end
        cyc(tag, en_after);
        clk_ctrl_reg_sel24 = 3'b000;
        pwdata24           = 16'h0000;
    endtask

    initial begin
        p_reset24          = 1'b1;
        pwdata24           = 16'h0000;
        clk_ctrl_reg_sel24 = 3'b000;
        sync_restart24     = 1'b0;
        ext_clk24          = 3'b000;
        exp_regs           = 21'h0;

        repeat (2) cyc("rst", 3'b000);
        p_reset24 = 1'b0;
        cyc("rel", 3'b111);
        repeat (3) cyc("run", 3'b111);

        // Ch1 divide by 16.
        wr(3'b001, 16'h0007, 7'h07, 3'b110, "wr_ch1");
        for (int k = 1; k <= 40; k++) cyc("div16", {2'b11, (k % 16 == 0)});

        // Ch1 and ch3 loaded together, divide by 4.
        wr(3'b101, 16'h0003, 7'h03, 3'b010, "wr_multi");
        for (int k = 1; k <= 6; k++) cyc("div4", {(k % 4 == 0), 1'b1, (k % 4 == 0)});

        // Restart while counters sit at 2, with a same-cycle ch2 write.
        sync_restart24     = 1'b1;
        clk_ctrl_reg_sel24 = 3'b010;
        pwdata24           = 16'h0001;
        exp_regs[13:7]     = 7'h01;
        cyc("restart", 3'b000);
        sync_restart24     = 1'b0;
        clk_ctrl_reg_sel24 = 3'b000;
        pwdata24           = 16'h0000;
        for (int j = 1; j <= 8; j++) cyc("post_restart", {(j % 4 == 0), (j % 2 == 0), (j % 4 == 0)});

`ifdef TTC_EXT_CLK_EN
        wr(3'b111, 16'h0000, 7'h00, 3'b000, "clr_all");
        wr(3'b010, 16'h0020, 7'h20, 3'b101, "wr_ext_rise");
        for (int n = 0; n < 32; n++) begin
            ext_clk24[1] = ((n % 8) < 4);
            cyc("ext_rise", {1'b1, (n >= 2 && ((n - 2) % 8 == 0)), 1'b1});
        end
        wr(3'b010, 16'h0060, 7'h60, 3'b101, "wr_ext_fall");
        for (int n = 0; n < 32; n++) begin
            ext_clk24[1] = ((n % 8) < 4);
            cyc("ext_fall", {1'b1, (n >= 2 && ((n - 2) % 8 == 4)), 1'b1});
        end
        ext_clk24 = 3'b000;
        wr(3'b111, 16'h0000, 7'h00, 3'b000, "clr_ext");
`else
        wr(3'b001, 16'hFFE0, 7'h00, 3'b000, "wr_noext");
        for (int j = 10; j <= 17; j++) begin
            ext_clk24 = ((j % 4) < 2) ? 3'b111 : 3'b000;
            cyc("noext", {(j % 4 == 0), (j % 2 == 0), 1'b1});
        end
        ext_clk24 = 3'b000;
        wr(3'b111, 16'h0000, 7'h00, 3'b000, "clr_noext");
`endif
        cyc("idle", 3'b111);

        // Ch1 N=15, abort with reset after 1000 ticks.
        wr(3'b001, 16'h001F, 7'h1F, 3'b110, "wr_n15");
        for (int k = 1; k <= 1000; k++) cyc("n15", 3'b110);
        #3;
        p_reset24 = 1'b1;
        exp_regs  = 21'h0;
        #1;
        expect_now("async_rst", 3'b000);
        compare_front();
        repeat (3) cyc("in_rst", 3'b000);
        p_reset24 = 1'b0;
        cyc("rel2", 3'b111);
        cyc("run2", 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ttc_count_sched24.md
TTC_COUNT_SCHED24 -- requirements
Module: ttc_count_sched24

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port names pclk24 and p_reset24.
REQ-002 pclk24  input  1  system clock; all state on its rising edge.
REQ-003 p_reset24  input  1  asynchronous active-high reset.
REQ-004 pwdata24  input  16  write data; bits [6:0] used.
REQ-005 clk_ctrl_reg_sel24  input  3  per-channel clock-control write strobe; bit i-1 selects channel i (1..3).
REQ-006 sync_restart24  input  1  one-cycle pulse; restarts all three prescalers together.
REQ-007 ext_clk24  input  3  asynchronous external count clocks, one per channel.
REQ-008 clk_ctrl_reg_out24  output  21  channel i control register at bits [7i-1:7i-7].
REQ-009 count_en24  output  3  registered one-cycle count-enable pulse per channel, to the counter.

Function
REQ-010 Control register per channel: bit0 prescale enable; bits[4:1] prescale value N; bit5 source select (0 pclk24, 1 ext_clk24); bit6 ext edge (0 rising, 1 falling).
REQ-011 A strobe bit high SHALL load pwdata24[6:0] into that channel's register at the next edge; several strobes in one cycle load all selected channels.
REQ-012 Each ext_clk24 bit SHALL pass a 2-flop synchronizer then an edge-history flop; edge = sync2 XOR hist, qualified by bit6 direction.
REQ-013 Tick per channel: pclk24 source -> every cycle; ext source -> detected selected edge.
REQ-014 Prescale disabled: count_en24[i] SHALL be high the cycle after each tick.
REQ-015 Prescale enabled: 16-bit prescale counter increments on each tick, wraps at 2^(N+1)-1; count_en24[i] high the cycle after the tick wrapping it to 0 (divide by 2^(N+1), N=15 -> 65536).
REQ-016 Write to a channel's register SHALL clear its prescale counter and force count_en24[i] low next cycle; new settings take effect on the following tick.
REQ-017 sync_restart24 SHALL clear all prescale counters and force all count_en24 low next cycle; it has priority over a same-cycle tick; a same-cycle register write still loads.
REQ-018 Source or edge change SHALL NOT itself generate a tick; the edge-history flop keeps tracking regardless of source.
REQ-019 ext_clk24 high and low phases SHALL be >= 2 pclk24 periods; latency ext edge to count_en24 = 3 pclk24 edges after first sampling edge.
REQ-020 Channels SHALL be fully independent except for sync_restart24.

Reset
REQ-021 Under p_reset24: all control registers 7'h00, prescale counters 0, synchronizer and history flops 0, count_en24 3'b000.
REQ-022 Reset mid-count SHALL abort immediately; first pclk24-mode pulse appears the cycle after the first edge with p_reset24 low.

Configuration
REQ-023 Macro TTC_EXT_CLK_EN defined: external-clock path per REQ-012/013/019 built.
REQ-024 TTC_EXT_CLK_EN undefined: no synchronizers; ext_clk24 ignored; bits 5 and 6 stored as 0 and read back 0; pclk24 only source.

Verification
REQ-025 Reset release, all regs 0 -> count_en24 = 3'b111 every cycle from first edge after release.
REQ-026 Ch1 write 7'h07 (prescale on, N=3) -> count_en24[1] one pulse every 16 cycles, first 16 cycles after write; ch2/ch3 unaffected.
REQ-027 Ch2 write 7'h20, ext_clk24[2] square wave period 8 cycles -> one pulse per rising edge, 3 cycles latency; 7'h60 -> pulses on falling edges.
REQ-028 Ch3 N=1 prescale, sync_restart24 pulsed when counter = 2 -> no pulse next cycle, next pulse 4 ticks after restart.
REQ-029 Build without TTC_EXT_CLK_EN, write 7'h60 to ch1 -> readback 7'h00, count_en24[1] every cycle, ext_clk24 toggling has no effect.
REQ-030 p_reset24 asserted mid-division (ch1 N=15, count 1000) -> count_en24 and all registers 0 immediately, no pulse during reset.
